// File: rtl/vec_vsetvl_ctrl.sv
// Vector configuration sequencer: legality check, VLMAX and new vl for vsetvli/vsetivli/vsetvl,
// followed by a single CSR write strobe and a vl response for the scalar rd writeback.
module vec_vsetvl_ctrl #(
  parameter int XLEN = 32,
  parameter int VLEN = 512,
  parameter int ELEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [1:0]      inst_kind,
  input  logic            rs1_is_x0,
  input  logic            rd_is_x0,
  input  logic [XLEN-1:0] avl_i,
  input  logic [XLEN-1:0] vtype_i,
  input  logic [XLEN-1:0] vl_cur_i,
  output logic            csrwr_en,
  output logic [XLEN-1:0] vtype_o,
  output logic [XLEN-1:0] vl_o,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_vl
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] VLEN_X  = XLEN'(VLEN);
  localparam logic [XLEN-1:0] ELEN_X  = XLEN'(ELEN);
  localparam logic [XLEN-1:0] EIGHT_X = XLEN'(8);
  localparam logic [XLEN-1:0] VILL_X  = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [1:0]        kind_q, kind_d;
  logic              rs1_x0_q, rs1_x0_d;
  logic              rd_x0_q, rd_x0_d;
  logic [XLEN-1:0]   avl_q, avl_d;
  logic [XLEN-1:0]   vtype_in_q, vtype_in_d;
  logic [XLEN-1:0]   vl_cur_q, vl_cur_d;
  logic [XLEN-1:0]   vtype_o_q, vtype_o_d;
  logic [XLEN-1:0]   vl_o_q, vl_o_d;
  logic [XLEN-1:0]   resp_vl_q, resp_vl_d;

  logic [2:0]        vsew;
  logic [2:0]        vlmul;
  logic              frac_lmul;
  logic              illegal;
  logic [XLEN-1:0]   sew_bits;
  logic [XLEN-1:0]   elen_frac;
  logic [XLEN-1:0]   vlmax_base;
  logic [XLEN-1:0]   vlmax;
  logic [XLEN-1:0]   vl_req;
  logic [XLEN-1:0]   vl_new;

  // Fractional LMUL (vlmul 5..7) divides by 8, 4, 2, i.e. a right shift of 8-vlmul.
  always_comb begin
    vsew       = vtype_in_q[5:3];
    vlmul      = vtype_in_q[2:0];
    frac_lmul  = vlmul[2] && (vlmul != 3'd4);
    sew_bits   = EIGHT_X << vsew;
    elen_frac  = ELEN_X >> (4'd8 - {1'b0, vlmul});
    illegal    = vsew[2] || (vlmul == 3'd4) || (|vtype_in_q[XLEN-1:8]) ||
                 (frac_lmul && (sew_bits > elen_frac));
    vlmax_base = VLEN_X >> ({1'b0, vsew} + 4'd3);
    vlmax      = frac_lmul ? (vlmax_base >> (4'd8 - {1'b0, vlmul})) : (vlmax_base << vlmul);

    // Only rs1==x0 && rd==x0 keeps the current vl; every other case clips a request to VLMAX.
    vl_req = vl_cur_q;
    if (kind_q == 2'd1) begin
      vl_req = {{(XLEN-5){1'b0}}, avl_q[4:0]};
    end else if (!rs1_x0_q) begin
      vl_req = avl_q;
    end else if (!rd_x0_q) begin
      vl_req = vlmax;
    end
    vl_new = (vl_req > vlmax) ? vlmax : vl_req;
  end

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    rs1_x0_d   = rs1_x0_q;
    rd_x0_d    = rd_x0_q;
    avl_d      = avl_q;
    vtype_in_d = vtype_in_q;
    vl_cur_d   = vl_cur_q;
    vtype_o_d  = vtype_o_q;
    vl_o_d     = vl_o_q;
    resp_vl_d  = resp_vl_q;
    inst_ready = 1'b0;
    csrwr_en   = 1'b0;
    resp_valid = 1'b0;

    case (state_q)
      IDLE: begin
        inst_ready = 1'b1;
        if (inst_valid) begin
          kind_d     = inst_kind;
          rs1_x0_d   = rs1_is_x0;
          rd_x0_d    = rd_is_x0;
          avl_d      = avl_i;
          vtype_in_d = vtype_i;
          vl_cur_d   = vl_cur_i;
          state_d    = CALC;
        end
      end
      CALC: begin
        vtype_o_d = illegal ? VILL_X : {{(XLEN-8){1'b0}}, vtype_in_q[7:0]};
        vl_o_d    = illegal ? '0 : vl_new;
        state_d   = COMMIT;
      end
      COMMIT: begin
        csrwr_en  = 1'b1;
        resp_vl_d = vl_o_q;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      kind_q     <= '0;
      rs1_x0_q   <= 1'b0;
      rd_x0_q    <= 1'b0;
      avl_q      <= '0;
      vtype_in_q <= '0;
      vl_cur_q   <= '0;
      vtype_o_q  <= '0;
      vl_o_q     <= '0;
      resp_vl_q  <= '0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      rs1_x0_q   <= rs1_x0_d;
      rd_x0_q    <= rd_x0_d;
      avl_q      <= avl_d;
      vtype_in_q <= vtype_in_d;
      vl_cur_q   <= vl_cur_d;
      vtype_o_q  <= vtype_o_d;
      vl_o_q     <= vl_o_d;
      resp_vl_q  <= resp_vl_d;
    end
  end

  assign vtype_o = vtype_o_q;
  assign vl_o    = vl_o_q;
  assign resp_vl = resp_vl_q;

endmodule
